dino_game_ctrl: RTL

- Frame-rate game sequencer for the dino arcade display path.
- Consumes the VGA frame-end pulse, the collision flag and the player buttons.
- Produces the dino and obstacle coordinates plus the game_over/pause flags that the VGA controller renders.
- Owns the game FSM, jump trajectory, obstacle scroll/respawn and score counter.

---
 rtl/dino_game_pkg.sv | 23 ++
 rtl/dino_btn_sync.sv | 36 +++
 rtl/dino_game_ctrl.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/dino_game_pkg.sv
// Shared types and constants for the dino game sequencer.
package dino_game_pkg;

   // Internal coordinate width; outputs are zero-extended to 32 bits
   localparam int COORD_W          = 12;
   // Speed-up: step grows by (score >> SPEEDUP_SHIFT), capped at CAP_MULT*OBS_STEP
   localparam int SPEEDUP_SHIFT    = 3;
   localparam int SPEEDUP_CAP_MULT = 4;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      RUN    = 2'd1,
      PAUSED = 2'd2,
      OVER   = 2'd3
   } game_state_t;

   typedef enum logic [1:0] {
      GROUND = 2'd0,
      UP     = 2'd1,
      DOWN   = 2'd2
   } jump_phase_t;

endpackage

// File: rtl/dino_btn_sync.sv
// Button front end: 2-flop synchronizer, rising-edge detect and a pending
// flag that survives until the next frame strobe clears it.
module dino_btn_sync (
   input  logic clk,
   input  logic reset,
   input  logic i_btn,
   input  logic i_clear,
   output logic o_pending
);

   logic r_meta;
   logic r_sync;
   logic r_sync_q;
   logic r_pending;
   logic w_edge;

   assign w_edge    = r_sync & ~r_sync_q;
   assign o_pending = r_pending;

   // Synchronize the button, detect its rising edge, latch a pending press.
   // A press landing on the clearing strobe is kept for the following frame.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_meta    <= 1'b0;
         r_sync    <= 1'b0;
         r_sync_q  <= 1'b0;
         r_pending <= 1'b0;
      end else begin
         r_meta    <= i_btn;
         r_sync    <= r_meta;
         r_sync_q  <= r_sync;
         r_pending <= w_edge | (r_pending & ~i_clear);
      end
   end

endmodule

// File: rtl/dino_game_ctrl.sv
// Frame-rate game sequencer: game FSM, jump trajectory, obstacle scroll and
// score. Optional macro DINO_GAME_SPEEDUP_EN makes the obstacle step grow
// with the score.
import dino_game_pkg::*;

module dino_game_ctrl #(
   parameter int DINO_X      = 240,
   parameter int GROUND_Y    = 320,
   parameter int JUMP_HEIGHT = 120,
   parameter int JUMP_STEP   = 4,
   parameter int OBS_SPAWN_X = 680,
   parameter int OBS_STEP    = 4,
   parameter int SCORE_W     = 16
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               frame_tick,
   input  logic               collision,
   input  logic               jump_btn,
   input  logic               pause_btn,
   output logic [31:0]        x_coor,
   output logic [31:0]        y_coor,
   output logic [31:0]        x_coor_obstacle,
   output logic [31:0]        y_coor_obstacle,
   output logic               game_over,
   output logic               pause,
   output logic [SCORE_W-1:0] score
);

   localparam logic [COORD_W-1:0] LP_DINO_X      = COORD_W'(DINO_X);
   localparam logic [COORD_W-1:0] LP_GROUND_Y    = COORD_W'(GROUND_Y);
   localparam logic [COORD_W-1:0] LP_JUMP_HEIGHT = COORD_W'(JUMP_HEIGHT);
   localparam logic [COORD_W-1:0] LP_JUMP_STEP   = COORD_W'(JUMP_STEP);
   localparam logic [COORD_W-1:0] LP_SPAWN_X     = COORD_W'(OBS_SPAWN_X);
   localparam logic [COORD_W-1:0] LP_OBS_STEP    = COORD_W'(OBS_STEP);

   game_state_t        r_state;
   jump_phase_t        r_phase;
   logic [COORD_W-1:0] r_y;
   logic [COORD_W-1:0] r_obs_x;
   logic [SCORE_W-1:0] r_score;
   logic               r_game_over;
   logic               r_pause;
   logic               r_tick_q;

   logic               w_strobe;
   logic               w_jump_pend;
   logic               w_pause_pend;
   logic [COORD_W-1:0] w_step;
   logic [COORD_W-1:0] w_y_up;
   logic [COORD_W-1:0] w_y_dn;
   logic               w_apex;

   assign w_strobe = frame_tick & ~r_tick_q;
   assign w_y_up   = r_y - LP_JUMP_STEP;
   assign w_y_dn   = r_y + LP_JUMP_STEP;
   assign w_apex   = (LP_GROUND_Y - w_y_up) == LP_JUMP_HEIGHT;

`ifdef DINO_GAME_SPEEDUP_EN
   localparam logic [SCORE_W:0] LP_STEP_CAP = (SCORE_W+1)'(SPEEDUP_CAP_MULT * OBS_STEP);
   logic [SCORE_W:0] w_step_raw;
   assign w_step_raw = (SCORE_W+1)'(OBS_STEP) + (SCORE_W+1)'(r_score >> SPEEDUP_SHIFT);
   assign w_step     = (w_step_raw > LP_STEP_CAP) ? LP_STEP_CAP[COORD_W-1:0]
                                                  : w_step_raw[COORD_W-1:0];
`else
   assign w_step = LP_OBS_STEP;
`endif

   dino_btn_sync u_jump_sync (
      .clk       (clk),
      .reset     (reset),
      .i_btn     (jump_btn),
      .i_clear   (w_strobe),
      .o_pending (w_jump_pend)
   );

   dino_btn_sync u_pause_sync (
      .clk       (clk),
      .reset     (reset),
      .i_btn     (pause_btn),
      .i_clear   (w_strobe),
      .o_pending (w_pause_pend)
   );

   assign x_coor          = {{(32-COORD_W){1'b0}}, LP_DINO_X};
   assign y_coor          = {{(32-COORD_W){1'b0}}, r_y};
   assign x_coor_obstacle = {{(32-COORD_W){1'b0}}, r_obs_x};
   assign y_coor_obstacle = {{(32-COORD_W){1'b0}}, LP_GROUND_Y};
   assign game_over       = r_game_over;
   assign pause           = r_pause;
   assign score           = r_score;

   // Game FSM with jump/obstacle/score datapath, advanced once per frame strobe.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state     <= IDLE;
         r_phase     <= GROUND;
         r_y         <= LP_GROUND_Y;
         r_obs_x     <= LP_SPAWN_X;
         r_score     <= '0;
         r_game_over <= 1'b0;
         r_pause     <= 1'b0;
         r_tick_q    <= 1'b0;
      end else begin
         r_tick_q <= frame_tick;
         if (w_strobe) begin
            case (r_state)
               IDLE: begin
                  if (w_jump_pend) r_state <= RUN;
               end
               RUN: begin
                  if (collision) begin
                     r_state     <= OVER;
                     r_game_over <= 1'b1;
                  end else if (w_pause_pend) begin
                     r_state <= PAUSED;
                     r_pause <= 1'b1;
                  end else begin
                     case (r_phase)
                        GROUND: begin
                           if (w_jump_pend) begin
                              r_y     <= w_y_up;
                              r_phase <= w_apex ? DOWN : UP;
                           end
                        end
                        UP: begin
                           r_y <= w_y_up;
                           if (w_apex) r_phase <= DOWN;
                        end
                        DOWN: begin
                           r_y <= w_y_dn;
                           if (w_y_dn == LP_GROUND_Y) r_phase <= GROUND;
                        end
                        default: r_phase <= GROUND;
                     endcase
                     // No-wrap scroll: respawn instead of underflowing
                     if (r_obs_x < w_step) begin
                        r_obs_x <= LP_SPAWN_X;
                        if (r_score != '1) r_score <= r_score + 1'b1;
                     end else begin
                        r_obs_x <= r_obs_x - w_step;
                     end
                  end
               end
               PAUSED: begin
                  if (w_pause_pend) begin
                     r_state <= RUN;
                     r_pause <= 1'b0;
                  end
               end
               OVER: begin
                  if (w_jump_pend) begin
                     r_state     <= RUN;
                     r_game_over <= 1'b0;
                     r_phase     <= GROUND;
                     r_y         <= LP_GROUND_Y;
                     r_obs_x     <= LP_SPAWN_X;
                     r_score     <= '0;
                  end
               end
               default: r_state <= IDLE;
            endcase
         end
      end
   end

endmodule
